instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/ifu_pkg.sv | 14 +
 rtl/ifu_fifo.sv | 55 +++++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the NOP filler instruction and the sequential fetch step.
package ifu_pkg;

    typedef logic [1:0] ifu_state_t;

    localparam ifu_state_t ST_IDLE = 2'd0;
    localparam ifu_state_t ST_WAIT = 2'd1;
    localparam ifu_state_t ST_DROP = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/ifu_fifo.sv
// Fetched-instruction buffer: synchronous FIFO of {instr, pc} entries with
// flush; a push into a full buffer succeeds when a pop happens in the same cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [63:0]              din,
    output logic [63:0]              head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetch FSM feeding a small
// instruction buffer. Define IFU_PERF_CNT_EN to add fetch/stall counters.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned     CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    ifu_state_t    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [CW-1:0] fifo_count;
    logic [63:0]   fifo_head;
    logic          buf_empty;
    logic          issue;
    logic          push;
    logic          pop;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Issue decision uses the occupancy before this cycle's push/pop so the
    // buffer can never be over-committed by the single outstanding request.
    always_comb begin
        issue = 1'b0;
        push  = 1'b0;
        if (!reset && !redirect_valid) begin
            case (state)
                ST_IDLE: issue = (fifo_count < DEPTH_C);
                ST_WAIT: begin
                    if (imem_valid) begin
                        push  = 1'b1;
                        issue = (({1'b0, fifo_count} + 1'b1) < DEPTH_W);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            state    <= (state != ST_IDLE && !imem_valid) ? ST_DROP : ST_IDLE;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
                req_pc   <= fetch_pc;
            end
            case (state)
                ST_IDLE: if (issue) state <= ST_WAIT;
                ST_WAIT: if (imem_valid) state <= issue ? ST_WAIT : ST_IDLE;
                ST_DROP: if (imem_valid) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({imem_rdata, req_pc}),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign buf_empty   = (fifo_count == '0);
    assign if_id_valid = !reset && !buf_empty && !redirect_valid;
    assign pop         = if_id_valid && id_ready;
    assign if_id_instr = (reset || buf_empty) ? NOP_INSTR : fifo_head[63:32];
    assign if_id_pc    = (reset || buf_empty) ? '0 : fifo_head[31:0];
    assign imem_req    = issue;
    assign imem_addr   = issue ? fetch_pc : '0;

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue)                      perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            if (if_id_valid && !id_ready)   perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif

endmodule
